// File: rtl/gate_truth_table_checker_pkg.sv
// gate_check_pkg
// Definitions shared by the truth-table checker and its settle timer:
//   - state_t     : checker state encoding (IDLE, DRIVE, SAMPLE, DONE)
//   - NUM_VECTORS : number of input combinations of a 2-input gate
//   - TT_*        : expected-output tables, bit index = {a,b}
package gate_check_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_VECTORS = 4;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/gate_truth_table_checker_settle_timer.sv
// settle_timer
// Counts the cycles a gate input vector has been held. The count is cleared
// while clr is high and advances while en is high. expired is high during the
// last cycle of a SETTLE_CYCLES-long hold, so the owner can leave the hold
// state on that edge.
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   clr     : synchronous clear of the count (wins over en)
//   en      : count enable
//   expired : count has reached SETTLE_CYCLES-1
module settle_timer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // Final count value of a hold; the hold lasts SETTLE_CYCLES cycles from 0.
  localparam logic [3:0] LAST_COUNT = 4'(SETTLE_CYCLES - 1);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 4'd0;
    end else if (en) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = en && (count_q == LAST_COUNT);

endmodule

// File: rtl/gate_truth_table_checker.sv
// gate_truth_table_checker
// Walks a 2-input gate through the vectors {a,b} = 00,01,10,11, holds each for
// SETTLE_CYCLES cycles, samples c for one cycle and compares it with EXPECT.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset, abandons any run
//   start     : begin a run when idle or done (ignored while busy)
//   gate_a    : registered drive of input a of the gate under test
//   gate_b    : registered drive of input b of the gate under test
//   gate_c    : output c of the gate under test
//   busy      : run in progress
//   done      : run complete, results valid until the next start
//   pass      : done with no mismatches
//   err_count : number of mismatching vectors (0..4)
//   err_mask  : bit k set when vector k mismatched
module gate_truth_table_checker
  import gate_check_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 1,
  parameter logic [3:0] EXPECT        = 4'b1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       gate_a,
  output logic       gate_b,
  input  logic       gate_c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] err_mask
);

  localparam int IDX_W = $clog2(NUM_VECTORS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             gate_a_q, gate_a_d;
  logic             gate_b_q, gate_b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2:0]       err_count_q, err_count_d;
  logic [3:0]       err_mask_q, err_mask_d;
  logic             settle_expired;

  // The timer only runs in DRIVE and sits at zero otherwise, so every DRIVE
  // visit starts a fresh hold.
  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q != DRIVE),
    .en     (state_q == DRIVE),
    .expired(settle_expired)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_count_d = err_count_q;
    err_mask_d  = err_mask_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = DRIVE;
          idx_d       = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          err_count_d = 3'd0;
          err_mask_d  = 4'd0;
        end
      end
      DRIVE: begin
        if (settle_expired) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (gate_c != EXPECT[idx_q]) begin
          err_mask_d[idx_q] = 1'b1;
          err_count_d       = err_count_q + 3'd1;
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = DRIVE;
          idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Drive the gate from the next state so the new vector appears on the
    // same edge that enters DRIVE, and the inputs return to 0 outside a run.
    gate_a_d = 1'b0;
    gate_b_d = 1'b0;
    if ((state_d == DRIVE) || (state_d == SAMPLE)) begin
      gate_a_d = idx_d[1];
      gate_b_d = idx_d[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      gate_a_q    <= 1'b0;
      gate_b_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_count_q <= 3'd0;
      err_mask_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gate_a_q    <= gate_a_d;
      gate_b_q    <= gate_b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_count_q <= err_count_d;
      err_mask_q  <= err_mask_d;
    end
  end

  assign gate_a    = gate_a_q;
  assign gate_b    = gate_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_count = err_count_q;
  assign err_mask  = err_mask_q;
  // done and err_count are both registered, so pass cannot pulse outside DONE.
  assign pass      = done_q && (err_count_q == 3'd0);

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Bench for gate_truth_table_checker. Two checkers share clk/rst:
//   dut0: SETTLE_CYCLES=1, EXPECT=AND
//   dut1: SETTLE_CYCLES=3, EXPECT=XOR
// Each drives a behavioural gate whose truth table (tt0/tt1) is chosen per
// run, so any gate (AND, NAND, tied-0, random) can be wired in.
module tb_gate_truth_table_checker;
  import gate_check_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1;
  logic       a0, b0, c0, busy0, done0, pass0;
  logic       a1, b1, c1, busy1, done1, pass1;
  logic [2:0] cnt0, cnt1;
  logic [3:0] mask0, mask1;
  logic [3:0] tt0, tt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign c0 = tt0[{a0, b0}];
  assign c1 = tt1[{a1, b1}];

  gate_truth_table_checker #(.SETTLE_CYCLES(1), .EXPECT(TT_AND)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .gate_a(a0), .gate_b(b0),
    .gate_c(c0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(cnt0), .err_mask(mask0)
  );

  gate_truth_table_checker #(.SETTLE_CYCLES(3), .EXPECT(TT_XOR)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .gate_a(a1), .gate_b(b1),
    .gate_c(c1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(cnt1), .err_mask(mask1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " d0 outs"}, {a0, b0, busy0, done0, pass0, 3'b0}, 8'h00);
    chk({tag, " d0 cnt"}, {5'b0, cnt0}, 8'h00);
    chk({tag, " d0 mask"}, {4'b0, mask0}, 8'h00);
    chk({tag, " d1 outs"}, {a1, b1, busy1, done1, pass1, 3'b0}, 8'h00);
    chk({tag, " d1 cnt"}, {5'b0, cnt1}, 8'h00);
    chk({tag, " d1 mask"}, {4'b0, mask1}, 8'h00);
  endtask

  // One complete run on checker `which` with gate table `tt`. The model: the
  // run spans 4*(S+1) cycles, vector k occupies cycles k*(S+1)..k*(S+1)+S, and
  // a vector's verdict becomes visible once its whole slot has elapsed.
  // busy_pulses: pulse start at T0+5 and T0+9 (ignored while busy).
  // hold: keep start high through the run and check the immediate restart.
  task automatic run(input int which, input logic [3:0] tt, input string name,
                     input bit busy_pulses, input bit hold);
    int         s;
    int         per;
    logic [3:0] expv, bad, acc;
    logic [1:0] kv;
    bit         exp_busy, exp_done;
    logic       oa, ob, obusy, odone, opass;
    logic [2:0] ocnt;
    logic [3:0] omask;
    s    = (which == 0) ? 1 : 3;
    per  = s + 1;
    expv = (which == 0) ? TT_AND : TT_XOR;
    bad  = tt ^ expv;
    if (which == 0) tt0 = tt; else tt1 = tt;

    @(negedge clk);
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);  // edge T0 has passed; this is offset 0
    if (!hold) begin
      if (which == 0) start0 = 1'b0; else start1 = 1'b0;
    end

    for (int t = 0; t <= 4 * per; t++) begin
      exp_busy = (t < 4 * per);
      exp_done = (t == 4 * per);
      kv  = 2'(t / per);
      acc = 4'd0;
      for (int v = 0; v < 4; v++) if ((v + 1) * per <= t) acc[v] = bad[v];
      if (which == 0) begin
        oa = a0; ob = b0; obusy = busy0; odone = done0; opass = pass0;
        ocnt = cnt0; omask = mask0;
      end else begin
        oa = a1; ob = b1; obusy = busy1; odone = done1; opass = pass1;
        ocnt = cnt1; omask = mask1;
      end
      chk($sformatf("%s t%0d ab", name, t), {6'b0, oa, ob},
          exp_busy ? {6'b0, kv} : 8'h00);
      chk($sformatf("%s t%0d busy/done/pass", name, t), {5'b0, obusy, odone, opass},
          {5'b0, exp_busy, exp_done, exp_done && (bad == 4'd0)});
      chk($sformatf("%s t%0d mask", name, t), {4'b0, omask}, {4'b0, acc});
      chk($sformatf("%s t%0d cnt", name, t), {5'b0, ocnt}, 8'($countones(acc)));
      if (busy_pulses && which == 1) start1 = (t == 4 || t == 8);
      if (t < 4 * per) @(negedge clk);
    end

    if (hold) begin
      @(negedge clk);  // start still high in DONE: restarted, results cleared
      chk({name, " restart busy/done/pass"}, {5'b0, busy0, done0, pass0}, 8'h04);
      chk({name, " restart mask"}, {4'b0, mask0}, 8'h00);
      chk({name, " restart cnt"}, {5'b0, cnt0}, 8'h00);
      chk({name, " restart ab"}, {6'b0, a0, b0}, 8'h00);
      start0 = 1'b0;
    end
    $display("run %s: dut%0d tt=%b expect=%b checks=%0d errors=%0d",
             name, which, tt, expv, checks, errors);
  endtask

  initial begin
    logic [3:0] rtt;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; tt0 = TT_AND; tt1 = TT_XOR;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("after reset");

    run(0, TT_AND,  "and_ok",   1'b0, 1'b0);
    run(0, 4'b0000, "tie0",     1'b0, 1'b0);
    run(0, TT_NAND, "nand",     1'b0, 1'b0);
    run(0, TT_AND,  "restart",  1'b0, 1'b0);
    run(1, TT_XOR,  "xor_s3",   1'b1, 1'b0);
    run(1, TT_OR,   "or_vs_xor", 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) begin
      rtt = 4'($urandom_range(0, 15));
      run(0, rtt, $sformatf("rand0_%0d", i), 1'b0, 1'b0);
      rtt = 4'($urandom_range(0, 15));
      run(1, rtt, $sformatf("rand1_%0d", i), 1'b1, 1'b0);
    end

    // Start held high: one cycle of done, then an immediate restart.
    run(0, TT_NAND, "hold", 1'b0, 1'b1);

    // Asynchronous reset between edges mid-run (after edge T0+4).
    @(negedge clk);
    start0 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrun busy", {6'b0, busy0, busy1}, 8'h03);
    #2 rst = 1'b1;
    #1 chk_idle("async reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle("post reset");
    run(0, TT_AND, "after_rst0", 1'b0, 1'b0);
    run(1, TT_XOR, "after_rst1", 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_truth_table_checker.md
Name: gate_truth_table_checker

Overview:
- Self-checking stimulus/response stage for 2-input gate modules in the basic-gates library.
- Upstream of the gate under test: drives its a/b inputs through all four input combinations.
- Downstream of it: samples its output c and compares against a parameterised expected truth table.
- Reports per-vector mismatches, an error count and a pass flag; used as an on-chip checker beside every gate variant.

Parameters:
- SETTLE_CYCLES, 1, cycles gate_a/gate_b are held before gate_c is sampled; legal range 1..15.
- EXPECT, 4'b1000, expected c, bit index = {a,b}; 4'b1000 = AND, 4'b1110 = OR, 4'b0110 = XOR.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a run when sampled high in IDLE or DONE.
- gate_a  output  1  drives a of the gate under test.
- gate_b  output  1  drives b of the gate under test.
- gate_c  input  1  output c of the gate under test.
- busy  output  1  high while a run is in progress.
- done  output  1  high from run completion until the next start or reset.
- pass  output  1  done && err_count==0.
- err_count  output  3  number of mismatching vectors, 0..4.
- err_mask  output  4  bit idx set if vector idx mismatched.

Behaviour:
- Reset (async, any time, including mid-run): state=IDLE; all outputs 0; idx=0; settle counter=0. The run is abandoned with no partial results kept.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE/DONE, start=1 at edge T0:
  - next state DRIVE, idx=0, counter=0.
  - err_count=0, err_mask=0, done=0, busy=1.
- DRIVE:
  - gate_a=idx[1], gate_b=idx[0], registered outputs.
  - counter increments each cycle; after SETTLE_CYCLES cycles in DRIVE, go to SAMPLE.
- SAMPLE (exactly 1 cycle):
  - gate_a/gate_b unchanged.
  - At the exit edge, compare gate_c with EXPECT[idx]. On mismatch, set err_mask[idx] and increment err_count.
  - If idx==3: go to DONE, done=1 and busy=0 at that edge. Otherwise idx++, counter=0, go to DRIVE.
- Timing: vector k is compared at edge T0+(k+1)*(SETTLE_CYCLES+1); done rises at T0+4*(SETTLE_CYCLES+1).
- gate_a/gate_b are 0 in IDLE and DONE.
- start while busy: ignored, with no effect on idx, counter or results.
- start held high continuously: a new run begins at the first edge in DONE. Results of the finished run stay visible for exactly one cycle of done=1.
- err_count saturates by construction at 4 (3 bits, no overflow).
- pass is combinational from done and err_count; it never glitches high outside DONE.
- gate_c is assumed stable at SAMPLE. SETTLE_CYCLES covers any gate delay, so no synchroniser is needed (same clock domain).

Decomposition:
- Shared package gate_check_pkg:
  - state enum {IDLE, DRIVE, SAMPLE, DONE};
  - NUM_VECTORS=4;
  - truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111.
- One sub-module, settle_timer:
  - 4-bit counter with clear, enable and expired output against SETTLE_CYCLES;
  - same clk/rst.
- Checker top instantiates settle_timer. The bench instantiates the checker plus the gate under test.

Test Plan:
- AND gate, EXPECT=TT_AND, SETTLE_CYCLES=1, start pulse at T0 -> done=1 at T0+8, pass=1, err_count=0, err_mask=4'b0000; gate_a/gate_b sequence 00,01,10,11, each held 2 cycles.
- gate_c tied 0, EXPECT=TT_AND -> err_mask=4'b1000, err_count=1, pass=0.
- NAND gate wired in, EXPECT=TT_AND -> err_mask=4'b1111, err_count=4, pass=0.
- SETTLE_CYCLES=3 -> vector 0 compared at T0+4, done at T0+16; start pulses at T0+5 and T0+9 ignored (idx, busy unchanged).
- rst asserted mid-run at T0+5 (async, between edges) -> all outputs 0 immediately, state IDLE; a fresh start then completes with a clean pass.
- Restart from DONE after a failing run -> err_count/err_mask cleared at the start edge, second run with a correct gate gives pass=1.
